seq_booth_multiplier: RTL and testbench
=======================================

Name: seq_booth_multiplier

Overview:
- Parametrised, multi-cycle radix-4 Booth multiplier.
- Retires two multiplier bits per clock, so it is roughly half the latency of a radix-2 iterative design.
- Supports signed and unsigned operands, selected per transaction.
- Valid/ready handshakes on both input and output, so it sits directly in a datapath pipeline behind an operand FIFO.

Parameters:
- WIDTH, 32, operand width in bits; must be even and >= 4.
- EXT, WIDTH+2 (localparam), extended operand width; holds unsigned values as positive.
- ITER, EXT/2 (localparam), Booth iterations per product (17 at WIDTH=32).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands presented.
- in_ready  out  1  block can accept operands.
- signed_mode  in  1  1 = treat x/y as two's complement; 0 = unsigned. Sampled with operands.
- x  in  WIDTH  multiplicand.
- y  in  WIDTH  multiplier.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- product  out  2*WIDTH  result; signed or unsigned per captured mode.
- busy  out  1  high in CALC or DONE.

Behaviour:
- Reset: synchronous, active-high, on clk rising edge; overrides everything including mid-calculation.
  - State goes to IDLE.
  - Outputs: in_ready=1, out_valid=0, busy=0, product=0.
  - Internal registers (A, Q, q_1, counter, M) are cleared; any in-flight operation is discarded with no output.
- States: IDLE, CALC, DONE. The state is always one of these; there are no other encodings.
- Transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready:
    - capture M = ext(x) and Q = ext(y) to EXT bits.
    - ext() sign-extends when signed_mode=1, zero-extends when 0.
    - clear A (EXT+2 bits) and q_1; load counter=ITER-1; go to CALC.
  - CALC: one Booth step per cycle.
    - Recode triple {Q[1],Q[0],q_1}: 000/111 -> add 0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
    - M and 2M are sign-extended to EXT+2 bits before the add.
    - Then arithmetic-shift {A,Q,q_1} right by 2 (sign from A MSB).
    - When counter==0 after the step, latch product = low 2*WIDTH bits of {A,Q} and go to DONE; else decrement counter.
  - DONE: out_valid=1, product held stable.
    - On out_ready, go to IDLE and drop out_valid the next cycle.
    - out_valid never drops without out_ready.
- Latency: operands accepted at edge T; out_valid high from cycle T+ITER+1 (18 cycles at WIDTH=32).
- Throughput: one product per ITER+2 cycles minimum.
- in_ready=(state==IDLE). There is no overlap: a new transaction is accepted no earlier than the cycle after the DONE->IDLE handshake.
- Combinational paths: in_ready and out_valid are registered-state decodes. There is no combinational path from in_valid or out_ready to any output.
- in_valid outside IDLE is ignored. Operand and mode changes during CALC/DONE do not affect the result.
- product holds its last value in IDLE until the next DONE latch; it is only meaningful when out_valid=1.
- Overflow: none possible. Signed range -2^(2W-2)..2^(2W-2) fits; MIN*MIN = +2^(2W-2) is exact. Unsigned max (2^W-1)^2 fits in 2W bits.

Decomposition:
- Shared package mult_pkg:
  - state enum {IDLE, CALC, DONE}.
  - Booth op encoding {ZERO, ADD1, ADD2, SUB1, SUB2}.
  - function booth_recode(triple) -> op.
- Sub-module booth_r4_step: purely combinational one-iteration datapath (A, Q, q_1, M in; next A, Q, q_1 out), parametrised on EXT.
  - Top keeps the FSM, counter and registers.
  - The sub-module is reusable by a future fully-pipelined variant.

Test Plan:
- Signed negative: WIDTH=32, signed_mode=1, x=-7 (FFFFFFF9), y=3 -> product 64'hFFFF_FFFF_FFFF_FFEB; out_valid exactly 18 cycles after accept.
- Signed corners: x=y=32'h8000_0000 signed -> 64'h4000_0000_0000_0000; x=32'h8000_0000, y=32'h7FFF_FFFF -> 64'hC000_0000_8000_0000.
- Unsigned max: x=y=32'hFFFF_FFFF, signed_mode=0 -> 64'hFFFF_FFFE_0000_0001; same operands signed -> 64'h1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and product stable, in_ready=0; new in_valid ignored; accepted only after handshake.
- Reset mid-op: assert rst in 5th CALC cycle -> next cycle IDLE, in_ready=1, out_valid=0; next transaction 5*6 -> 30 correct.
- Param sweep WIDTH=8: exhaustive 65536 pairs x both modes vs reference model; latency 6 cycles (ITER=5).

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier: FSM states,
// Booth operation codes and the recoding function.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    ZERO,
    ADD1,
    ADD2,
    SUB1,
    SUB2
  } booth_op_e;

  // triple = {Q[1], Q[0], q_1}
  function automatic booth_op_e booth_recode(input logic [2:0] triple);
    booth_op_e op;
    case (triple)
      3'b001, 3'b010: op = ADD1;
      3'b011:         op = ADD2;
      3'b100:         op = SUB2;
      3'b101, 3'b110: op = SUB1;
      default:        op = ZERO;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_r4_step.sv
// One combinational radix-4 Booth iteration: recode, add/subtract M or 2M
// into A, then arithmetic-shift {A,Q,q_1} right by two.
module booth_r4_step
  import mult_pkg::*;
#(
  parameter int EXT = 34
) (
  input  logic [EXT+1:0] a_i,
  input  logic [EXT-1:0] q_i,
  input  logic           q1_i,
  input  logic [EXT-1:0] m_i,
  output logic [EXT+1:0] a_o,
  output logic [EXT-1:0] q_o,
  output logic           q1_o
);

  logic [EXT+1:0] m_ext;
  logic [EXT+1:0] m2_ext;
  logic [EXT+1:0] addend;
  logic [EXT+1:0] sum;

  assign m_ext  = {{2{m_i[EXT-1]}}, m_i};
  assign m2_ext = {m_i[EXT-1], m_i, 1'b0};

  always_comb begin
    addend = '0;
    case (booth_recode({q_i[1:0], q1_i}))
      ADD1:    addend = m_ext;
      ADD2:    addend = m2_ext;
      SUB1:    addend = -m_ext;
      SUB2:    addend = -m2_ext;
      default: addend = '0;
    endcase
  end

  assign sum  = a_i + addend;

  assign a_o  = {{2{sum[EXT+1]}}, sum[EXT+1:2]};
  assign q_o  = {sum[1:0], q_i[EXT-1:2]};
  assign q1_o = q_i[1];

endmodule

// File: rtl/seq_booth_multiplier.sv
// Multi-cycle radix-4 Booth multiplier with valid/ready on both sides;
// signed or unsigned operands selected per transaction.
module seq_booth_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  // state | meaning
  // IDLE  | waiting for operands, in_ready high
  // CALC  | one Booth step per cycle, counter runs ITER-1 down to 0
  // DONE  | product valid, held until out_ready

  localparam int EXT  = WIDTH + 2;
  localparam int ITER = EXT / 2;
  localparam int CW   = $clog2(ITER);

  state_e             state_q, state_d;
  logic [EXT+1:0]     a_q, a_d;
  logic [EXT-1:0]     q_q, q_d;
  logic               q1_q, q1_d;
  logic [EXT-1:0]     m_q, m_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic [EXT+1:0]     step_a;
  logic [EXT-1:0]     step_q;
  logic               step_q1;

  booth_r4_step #(
    .EXT (EXT)
  ) u_step (
    .a_i  (a_q),
    .q_i  (q_q),
    .q1_i (q1_q),
    .m_i  (m_q),
    .a_o  (step_a),
    .q_o  (step_q),
    .q1_o (step_q1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      m_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    q1_d    = q1_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          m_d     = {{2{signed_mode & x[WIDTH-1]}}, x};
          q_d     = {{2{signed_mode & y[WIDTH-1]}}, y};
          a_d     = '0;
          q1_d    = 1'b0;
          cnt_d   = CW'(ITER - 1);
          state_d = CALC;
        end
      end
      CALC: begin
        a_d  = step_a;
        q_d  = step_q;
        q1_d = step_q1;
        if (cnt_q == '0) begin
          // After ITER steps Q holds the low EXT product bits, A the rest.
          prod_d  = {step_a[WIDTH-3:0], step_q};
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC) || (state_q == DONE);
  assign product   = prod_q;

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Randomised self-checking bench for seq_booth_multiplier against a plain
// arithmetic reference product, plus directed corners, backpressure and reset.
module tb_seq_booth_multiplier;

  localparam int W    = 32;
  localparam int ITER = (W + 2) / 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic           signed_mode;
  logic [W-1:0]   x;
  logic [W-1:0]   y;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;

  int n_chk  = 0;
  int n_fail = 0;

  seq_booth_multiplier #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .signed_mode (signed_mode),
    .x           (x),
    .y           (y),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .product     (product),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
    logic [2*W-1:0] ea, eb;
    ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return ea * eb;
  endfunction

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = W'(1);
      2:       v = '1;
      3:       v = {1'b1, {(W-1){1'b0}}};
      4:       v = {1'b0, {(W-1){1'b1}}};
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Caller leaves the bench 1 ns after a rising edge with the DUT in IDLE.
  task automatic run_txn(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic m, input logic [2*W-1:0] exp, input int hold);
    int             cyc;
    logic [2*W-1:0] held;
    x           = a;
    y           = b;
    signed_mode = m;
    in_valid    = 1'b1;
    chk({tag, "_in_ready_idle"}, in_ready, 1);
    tick();
    in_valid    = 1'b0;
    x           = $urandom;
    y           = $urandom;
    signed_mode = $urandom_range(0, 1);
    cyc = 1;
    while (!out_valid && cyc < 4 * ITER) begin
      tick();
      cyc++;
    end
    chk({tag, "_latency"}, cyc, ITER + 1);
    chk({tag, "_product"}, product, exp);
    chk({tag, "_busy_done"}, busy, 1);
    chk({tag, "_in_ready_done"}, in_ready, 0);
    held = product;
    for (int i = 0; i < hold; i++) begin
      in_valid  = 1'b1;
      out_ready = 1'b0;
      tick();
      chk({tag, "_bp_out_valid"}, out_valid, 1);
      chk({tag, "_bp_product"}, product, held);
      chk({tag, "_bp_in_ready"}, in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_post_out_valid"}, out_valid, 0);
    chk({tag, "_post_in_ready"}, in_ready, 1);
    chk({tag, "_post_busy"}, busy, 0);
    chk({tag, "_post_product_held"}, product, held);
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic         m;

    rst         = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    signed_mode = 1'b0;
    x           = '0;
    y           = '0;
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_product", product, '0);
    rst = 1'b0;
    tick();

    run_txn("neg7x3", 32'hFFFF_FFF9, 32'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 0);
    run_txn("min_x_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 0);
    run_txn("min_x_max", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 64'hC000_0000_8000_0000, 0);
    run_txn("umax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 0);
    run_txn("smax_neg1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h1, 0);
    run_txn("backpressure", 32'd12345, 32'hFFFF_0000, 1'b1, ref_mul(32'd12345, 32'hFFFF_0000, 1'b1), 10);

    // Reset asserted during the fifth CALC cycle discards the operation.
    x           = 32'd1000;
    y           = 32'd77;
    signed_mode = 1'b0;
    in_valid    = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("midrst_busy_before", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_product", product, '0);
    repeat (ITER + 2) begin
      tick();
      chk("midrst_no_output", out_valid, 0);
    end
    run_txn("after_rst_5x6", 32'd5, 32'd6, 1'b0, 64'd30, 0);

    for (int i = 0; i < 150; i++) begin
      a = pick_operand();
      b = pick_operand();
      m = 1'($urandom_range(0, 1));
      run_txn("rand", a, b, m, ref_mul(a, b, m), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
